// File: rtl/ftdi_fifo_ctrl.sv
// ftdi_fifo_ctrl: FT245-style async byte FIFO controller.
// Reads host bytes (with channel-ID and flag-command decode) and drains an
// internal TX FIFO to the host. A read/write arbiter alternates under
// contention. Strobe and gap lengths are set by parameters.
module ftdi_fifo_ctrl #(
  parameter int N_ID       = 2,
  parameter int FLAG_BASE  = 3,
  parameter int N_FLAGS    = 4,
  parameter int TX_DEPTH   = 16,
  parameter int TX_AW      = 4,
  parameter int RD_CYCLES  = 2,
  parameter int WR_CYCLES  = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               rxf,
  input  logic               txe,
  output logic               oe,
  output logic               rd,
  output logic               wr,
  inout  wire  [7:0]         dq,
  output logic [7:0]         rx_data,
  output logic               rx_valid,
  output logic [N_ID-1:0]    id_accepted,
  output logic [N_FLAGS-1:0] flags,
  input  logic [7:0]         tx_data,
  input  logic               tx_push,
  output logic               tx_full,
  output logic [TX_AW:0]     tx_level,
  output logic               tx_drop
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_OE, S_RD_STROBE, S_WR_SETUP, S_WR_STROBE, S_GAP
  } state_t;

  // A single counter times the strobe and gap phases.
  localparam int          CW      = 8;
  localparam logic [CW-1:0] RD_LAST  = CW'(RD_CYCLES - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  // Flag-command range on the low nibble, widened so the upper bound fits.
  localparam logic [4:0] FLAG_LO = 5'(FLAG_BASE);
  localparam logic [4:0] FLAG_HI = 5'(FLAG_BASE + N_FLAGS);
  localparam logic [TX_AW:0] FULL_LVL = (TX_AW+1)'(TX_DEPTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_rd_q, last_rd_d;   // 1: last transfer served was a read
  logic [7:0]      rx_data_q;
  logic            rx_valid_q;
  logic [N_FLAGS-1:0] flags_q, flags_d;
  logic            tx_drop_q;

  logic [7:0]      mem_q [TX_DEPTH];
  logic [TX_AW-1:0] wptr_q, rptr_q;
  logic [TX_AW:0]  level_q, level_d;

  logic            capture;   // latch dq into rx_data at this edge
  logic            pop;       // retire FIFO head at this edge
  logic            push_ok;
  logic            drive_dq;
  logic            oe_n, rd_n, wr_n;
  logic            rd_req, wr_req;

  assign tx_full  = (level_q == FULL_LVL);
  assign push_ok  = tx_push & ~tx_full;
  assign rd_req   = ~rxf;
  assign wr_req   = ~txe & (level_q != '0);

  // Next-state, strobe outputs and transfer events of the arbiter FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_rd_d = last_rd_q;
    capture   = 1'b0;
    pop       = 1'b0;
    drive_dq  = 1'b0;
    oe_n      = 1'b1;
    rd_n      = 1'b1;
    wr_n      = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rd_req && wr_req)
          state_d = last_rd_q ? S_WR_SETUP : S_RD_OE;
        else if (rd_req)
          state_d = S_RD_OE;
        else if (wr_req)
          state_d = S_WR_SETUP;
      end
      S_RD_OE: begin
        oe_n    = 1'b0;
        cnt_d   = '0;
        state_d = S_RD_STROBE;
      end
      S_RD_STROBE: begin
        oe_n = 1'b0;
        rd_n = 1'b0;
        if (cnt_q == RD_LAST) begin
          capture   = 1'b1;
          last_rd_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_SETUP: begin
        drive_dq = 1'b1;
        cnt_d    = '0;
        state_d  = S_WR_STROBE;
      end
      S_WR_STROBE: begin
        drive_dq = 1'b1;
        wr_n     = 1'b0;
        if (cnt_q == WR_LAST) begin
          pop       = 1'b1;
          last_rd_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, counter and arbitration history.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_rd_q <= last_rd_d;
    end
  end

  assign oe = oe_n;
  assign rd = rd_n;
  assign wr = wr_n;
  assign dq = drive_dq ? mem_q[rptr_q] : 8'bz;

  // Receive register; rx_valid marks the clock after capture.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= capture;
      if (capture) rx_data_q <= dq;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

  // Channel-ID decode: bit k fires for byte value k+1 in the rx_valid clock.
  for (genvar k = 0; k < N_ID; k++) begin : g_id
    assign id_accepted[k] = rx_valid_q && (rx_data_q == 8'(k + 1));
  end

  // Flag command: 000s_iiii sets/clears flag (iiii - FLAG_BASE) to s.
  always_comb begin
    logic       is_flag;
    logic [4:0] nib;
    flags_d = flags_q;
    nib     = {1'b0, rx_data_q[3:0]};
    is_flag = rx_valid_q && (rx_data_q[7:5] == 3'b000) &&
              (nib >= FLAG_LO) && (nib < FLAG_HI);
    if (is_flag) begin
      for (int i = 0; i < N_FLAGS; i++) begin
        if ((nib - FLAG_LO) == 5'(i)) flags_d[i] = rx_data_q[4];
      end
    end
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (!n_rst) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;

  // Occupancy follows push/pop at the same edge; push+pop leaves it unchanged.
  always_comb begin
    level_d = level_q;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // TX FIFO pointers, level and drop indication.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      tx_drop_q <= tx_push & tx_full;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= tx_data;
  end

  assign tx_level = level_q;
  assign tx_drop  = tx_drop_q;

endmodule
